// File: rtl/rc5_key_expand.sv
// rtl/rc5_key_expand.sv - RC5-16 key schedule: sequential S-table init and key mixing
module rc5_key_expand #(
  parameter logic [15:0] P16         = 16'hB7E1,
  parameter logic [15:0] Q16         = 16'h9E37,
  parameter int          NUM_SUBKEYS = 34
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] key,
  input  logic [4:0]  num_rounds,
  output logic [15:0] subkeys [0:NUM_SUBKEYS-1],
  output logic        busy,
  output logic        done,
  output logic        keys_valid
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_MIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [15:0] s_tab [0:NUM_SUBKEYS-1];
  logic [15:0] l_reg [0:3];
  logic [15:0] a_reg, b_reg;
  logic [15:0] init_acc;
  logic [5:0]  idx;
  logic [5:0]  i_ptr;
  logic [1:0]  j_ptr;
  logic [6:0]  iter;
  logic [4:0]  rounds_reg;

  logic [5:0]  t_val;
  logic [6:0]  n_steps;
  logic [15:0] sum_a, a_new, ab_sum, b_new;
  logic [5:0]  i_next;
  logic        init_last, mix_last;

  function automatic logic [15:0] rotl16(input logic [15:0] x, input logic [3:0] n);
    logic [31:0] d;
    d = {x, x} << n;
    return d[31:16];
  endfunction

  // t = 2*(rounds+1); mixing covers 3*max(t,4) steps so every L word is hit 3+ times
  assign t_val     = 6'({rounds_reg, 1'b0}) + 6'd2;
  assign n_steps   = (t_val > 6'd4) ? 7'({1'b0, t_val} * 7'd3) : 7'd12;
  assign init_last = (idx == 6'(NUM_SUBKEYS - 1));
  assign mix_last  = (iter == n_steps - 7'd1);
  assign i_next    = (i_ptr == t_val - 6'd1) ? 6'd0 : i_ptr + 6'd1;

  always_comb begin
    sum_a  = s_tab[i_ptr] + a_reg + b_reg;
    a_new  = rotl16(sum_a, 4'd3);
    ab_sum = a_new + b_reg;
    b_new  = rotl16(l_reg[j_ptr] + ab_sum, ab_sum[3:0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start)     state_nxt = S_INIT;
      S_INIT: if (init_last) state_nxt = S_MIX;
      S_MIX:  if (mix_last)  state_nxt = S_DONE;
      S_DONE:                state_nxt = S_IDLE;
      default:               state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_INIT) || (state == S_MIX);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_SUBKEYS; k++) s_tab[k] <= '0;
      for (int k = 0; k < 4; k++) l_reg[k] <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      init_acc   <= '0;
      idx        <= '0;
      i_ptr      <= '0;
      j_ptr      <= '0;
      iter       <= '0;
      rounds_reg <= '0;
      keys_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            for (int k = 0; k < 4; k++) l_reg[k] <= key[16*k +: 16];
            rounds_reg <= (num_rounds > 5'd16) ? 5'd16 : num_rounds;
            a_reg      <= '0;
            b_reg      <= '0;
            init_acc   <= P16;
            idx        <= '0;
            i_ptr      <= '0;
            j_ptr      <= '0;
            iter       <= '0;
            keys_valid <= 1'b0;
          end
        end
        S_INIT: begin
          // running sum gives P + idx*Q without a multiplier
          s_tab[idx] <= init_acc;
          init_acc   <= init_acc + Q16;
          idx        <= idx + 6'd1;
        end
        S_MIX: begin
          s_tab[i_ptr] <= a_new;
          l_reg[j_ptr] <= b_new;
          a_reg        <= a_new;
          b_reg        <= b_new;
          i_ptr        <= i_next;
          j_ptr        <= j_ptr + 2'd1;
          iter         <= iter + 7'd1;
          if (mix_last) keys_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign subkeys = s_tab;

endmodule
